// File: rtl/i2c_target_regs.sv
// I2C target that bridges bus transfers to a synchronous 8-bit register port.
// Writes: pointer byte then data bytes (auto-increment). Reads start at the current pointer.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic [3:0] dbg_state
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] DEV       = 4'd1;
    localparam logic [3:0] DEV_ACK   = 4'd2;
    localparam logic [3:0] REG       = 4'd3;
    localparam logic [3:0] REG_ACK   = 4'd4;
    localparam logic [3:0] WR        = 4'd5;
    localparam logic [3:0] WR_ACK    = 4'd6;
    localparam logic [3:0] RD        = 4'd7;
    localparam logic [3:0] RD_ACK    = 4'd8;
    localparam logic [3:0] WAIT_STOP = 4'd9;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic [SYNC_STAGES:0]   arm_q, arm_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;

    logic [3:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] sr_q, sr_d;
    logic       rw_q, rw_d;
    logic       ack_q, ack_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       wr_en_q, wr_en_d;
    logic       rd_en_q, rd_en_d;
    logic       rd_pend_q, rd_pend_d;
    logic       busy_q, busy_d;

    logic scl_s, sda_s, armed;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];
    // Edges are ignored until the sync chain has refilled after reset, so a
    // release with SDA low and SCL high cannot look like a START.
    assign armed = arm_q[SYNC_STAGES];

    assign scl_rise  = armed &  scl_s & ~scl_prev_q;
    assign scl_fall  = armed & ~scl_s &  scl_prev_q;
    assign start_det = armed & scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_det  = armed & scl_s & scl_prev_q & ~sda_prev_q &  sda_s;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        arm_d      = {arm_q[SYNC_STAGES-1:0], 1'b1};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        rd_pend_d  = rd_en_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        rw_d     = rw_q;
        ack_d    = ack_q;
        sda_oe_d = sda_oe_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        busy_d   = busy_q;

        if (wr_en_q) begin
            addr_d = addr_q + 8'd1;
        end

        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d  = DEV;
            cnt_d    = 3'd0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                DEV: begin
                    if (scl_rise) begin
                        sr_d  = {sr_q[6:0], sda_s};
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (sr_q[6:0] == DEV_ADDR) begin
                                rw_d    = sda_s;
                                state_d = DEV_ACK;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                // sda_oe doubles as the phase flag: first fall starts the ACK, second ends it.
                DEV_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rd_en_d  = rw_q;
                        end else if (rw_q) begin
                            sda_oe_d = ~sr_q[7];
                            sr_d     = {sr_q[6:0], 1'b0};
                            cnt_d    = 3'd0;
                            state_d  = RD;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 3'd0;
                            state_d  = REG;
                        end
                    end else if (rd_pend_q) begin
                        sr_d = reg_rdata;
                    end
                end
                REG: begin
                    if (scl_rise) begin
                        sr_d  = {sr_q[6:0], sda_s};
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            addr_d  = {sr_q[6:0], sda_s};
                            state_d = REG_ACK;
                        end
                    end
                end
                REG_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 3'd0;
                            state_d  = WR;
                        end
                    end
                end
                WR: begin
                    if (scl_rise) begin
                        sr_d  = {sr_q[6:0], sda_s};
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_d = WR_ACK;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            wdata_d  = sr_q;
                            wr_en_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 3'd0;
                            state_d  = WR;
                        end
                    end
                end
                // cnt counts bits already clocked out; it wraps to 0 after the eighth rise.
                RD: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = RD_ACK;
                        end else begin
                            sda_oe_d = ~sr_q[7];
                            sr_d     = {sr_q[6:0], 1'b0};
                        end
                    end else if (scl_rise) begin
                        cnt_d = cnt_q + 3'd1;
                    end else if (rd_pend_q) begin
                        sda_oe_d = ~reg_rdata[7];
                        sr_d     = {reg_rdata[6:0], 1'b0};
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        ack_d = ~sda_s;
                        if (!sda_s) begin
                            addr_d = addr_q + 8'd1;
                        end
                    end else if (scl_fall) begin
                        if (ack_q) begin
                            rd_en_d = 1'b1;
                            cnt_d   = 3'd0;
                            state_d = RD;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            arm_q      <= '0;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            sr_q       <= 8'd0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            sda_oe_q   <= 1'b0;
            addr_q     <= 8'd0;
            wdata_q    <= 8'd0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_pend_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            arm_q      <= arm_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            sda_oe_q   <= sda_oe_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            rd_pend_q  <= rd_pend_d;
            busy_q     <= busy_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr_en = wr_en_q;
    assign reg_rd_en = rd_en_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (responder) that answers the team's I2C controller FSM on the same two-wire bus.
- Decodes START, 7-bit device address + R/W, an 8-bit register pointer, and write/read data bytes. Drives ACK and read data back open-drain.
- Bridges to a simple synchronous register-bank port. Sits between the pad-level SCL/SDA and the local register file.

Parameters:
- DEV_ADDR, 7'h50, 7-bit device address this target answers to.
- SYNC_STAGES, 2, flop stages on scl_in/sda_in before edge detection (minimum 2).

Ports:
- clk  in  1  system clock; period ≤ 1/8 of the SCL low or high time.
- nrst  in  1  asynchronous active-low reset.
- scl_in  in  1  SCL pad input, asynchronous.
- sda_in  in  1  SDA pad input, asynchronous.
- sda_oe  out  1  1 = pull SDA low; 0 = release. The pad drives 0 when oe=1.
- reg_addr  out  8  register pointer.
- reg_wdata  out  8  write data, valid with reg_wr_en.
- reg_wr_en  out  1  one-clk write strobe.
- reg_rd_en  out  1  one-clk read strobe.
- reg_rdata  in  8  read data; must be valid the clk after reg_rd_en.
- busy  out  1  1 from an addressed START until STOP.

Behaviour:
- Reset: sda_oe=0, reg_addr=0, reg_wdata=0, reg_wr_en=0, reg_rd_en=0, busy=0, state=IDLE, sync flops=1. Reset is asynchronous and takes effect mid-transfer. After release, the block ignores the bus until the next START.
- Bus conditioning:
  - scl_in and sda_in each pass through SYNC_STAGES flops.
  - scl_rise/scl_fall and sda edges are detected on the synced signals.
  - START = synced SDA falls while synced SCL=1. STOP = synced SDA rises while SCL=1.
- Timing: SDA is sampled on scl_rise. sda_oe changes only on scl_fall, the clk after the edge is detected.
- Bit counter is 3 bits, MSB first.
- States:
  - IDLE: wait for START.
  - DEV: shift 8 bits. If bits[7:1]==DEV_ADDR, go to DEV_ACK with rw=bit0. Otherwise go to IDLE and never drive SDA.
  - DEV_ACK: assert sda_oe for one SCL cycle and set busy=1. Then go to REG if rw=0. If rw=1, pulse reg_rd_en at the ACK scl_fall and go to RD.
  - REG: shift 8 bits into reg_addr, then go to REG_ACK (ACK), then WR.
  - WR: shift 8 bits. After bit 8, drive ACK. On that scl_fall, load reg_wdata and pulse reg_wr_en for one clk. reg_addr increments by 1 the clk after reg_wr_en, wrapping 8'hFF→8'h00. Then repeat WR.
  - RD: capture reg_rdata into the shift register the clk after reg_rd_en, then drive bits MSB first, each on scl_fall. After 8 bits, release SDA and go to RD_ACK.
  - RD_ACK: sample the controller's bit on scl_rise.
    - 0 (ACK): increment reg_addr with wrap, pulse reg_rd_en at scl_fall, return to RD.
    - 1 (NACK): release SDA and go to WAIT_STOP.
  - WAIT_STOP: ignore SCL until STOP or START.
- Reads have no register-pointer phase; they start at the current reg_addr.
- STOP in any state: go to IDLE, set sda_oe=0 and busy=0, and keep reg_addr.
- START in any state (repeated start): go to DEV and clear the bit counter. sda_oe is released immediately.
- START/STOP detection takes priority over a coincident scl edge in the same clk.
- A partial byte aborted by START/STOP produces no strobe.
- reg_wr_en and reg_rd_en are never asserted in the same clk.
- A write byte after NACK is impossible: the target always ACKs write bytes.

Test Plan:
- Reset: hold nrst=0 and toggle the bus → all outputs 0. Release nrst mid-byte → no ACK until a fresh START.
- Write: START, 0xA0, 0x10, 0x5A, 0xC3, STOP → ACK on all 4 bytes. reg_wr_en pulses twice: (addr 0x10, data 0x5A), then (addr 0x11, data 0xC3). Final reg_addr=0x12, busy=0 after STOP.
- Address mismatch: START, 0xA2 → sda_oe never asserted, no strobes, busy stays 0.
- Combined read: START, 0xA0, 0xFF, repeated START, 0xA1.
  - reg_rdata supplies 0x3C at addr 0xFF and 0x96 at addr 0x00.
  - Controller ACKs the first byte and NACKs the second, then STOP.
  - Required: SDA carries 0x3C then 0x96, reg_addr wraps to 0x00, exactly 2 reg_rd_en pulses.
- Aborted transfer: STOP after 4 bits of a write data byte → no reg_wr_en, state IDLE, reg_addr unchanged.
- Edge timing: check sda_oe transitions only within 2 clk after each synced scl_fall, never while SCL is high.
